fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the dual-clock FIFO among NREQ requesters in the wr_clk domain. Each requester has a valid/ready handshake. The arbiter grants one requester at a time for a burst of at most MAX_BURST words and drives the FIFO write port (write data, write strobe) from the granted requester. It respects the FIFO full flag, so no word is ever written into a full FIFO and no word is lost.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DWIDTH, 8, data width; matches the FIFO DWIDTH
- MAX_BURST, 4, maximum accepted words per grant (1..255)
- CWIDTH, 16, width of the accepted-word statistics counter

Ports:
- wr_clk  in  1  write-domain clock; same clock as the FIFO write port
- areset_n_wr  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester data valid
- req_data  in  NREQ*DWIDTH  per-requester data; requester i occupies bits [i*DWIDTH +: DWIDTH]
- req_ready  out  NREQ  per-requester accept; a word transfers when valid and ready are both high on a rising edge
- fifo_full  in  1  FIFO full flag
- fifo_datain  out  DWIDTH  FIFO write data
- fifo_write  out  1  FIFO write strobe
- grant_id  out  3  index of the granted or last-granted requester
- busy  out  1  high while in GRANT
- word_count  out  CWIDTH  total words written to the FIFO; wraps modulo 2^CWIDTH

## Operation
- FSM with two states, IDLE and GRANT. Reset state is IDLE.
- IDLE:
  - If any req_valid bit is high, select the first requester with valid high, searching from grant_id+1 upward modulo NREQ.
  - Register the selection into grant_id, clear burst_cnt and go to GRANT.
  - If no req_valid bit is high, stay in IDLE.
- GRANT, with g = grant_id:
  - accept = req_valid[g] & ~fifo_full.
  - On accept: burst_cnt increments and word_count increments.
  - Go to IDLE when accept occurs with burst_cnt == MAX_BURST-1 (burst exhausted).
  - Go to IDLE when req_valid[g] is low (requester released).
  - fifo_full high with req_valid[g] high: stall. Stay in GRANT and hold burst_cnt; the grant is not pre-empted.
- Combinational outputs:
  - req_ready[i] = (state==GRANT) & (g==i) & ~fifo_full.
  - fifo_write = accept.
  - fifo_datain = req_data slice g, driven in every state.
- Width rules:
  - burst_cnt is 8 bits.
  - grant_id is 3 bits; only values 0..NREQ-1 are ever held.
  - word_count is CWIDTH bits and wraps modulo 2^CWIDTH.
- Fairness: after a grant to g, g has the lowest priority at the next arbitration.

## Timing
- Reset values:
  - state IDLE, grant_id = NREQ-1 (so requester 0 wins the first arbitration), burst_cnt 0, word_count 0.
  - busy, fifo_write and req_ready are all 0.
- Reset asserted mid-burst: fifo_write and req_ready drop asynchronously with the reset. The partial burst is abandoned; words already accepted stay in the FIFO.
- Grant latency: req_valid rising in IDLE at edge n gives GRANT and busy from edge n+1. The first write is possible in the cycle after edge n+1.
- Each grant ends with one IDLE cycle, so each burst costs MAX_BURST+1 cycles at best.
  - Sustained throughput with all requesters busy: MAX_BURST/(MAX_BURST+1) words per cycle.
- fifo_full is sampled combinationally in the same cycle as the write. fifo_full is pessimistic (synchronized read pointer), so a write is never issued into a full FIFO.
- Simultaneous release and full: req_valid[g] low while fifo_full is high releases the grant; release has precedence.
- Requesters other than g see req_ready low and must hold their data.

## Test plan
- Single requester: reset; req_valid=4'b0001 streaming 0x10..0x17 with fifo_full=0.
  - Required: 8 fifo_write pulses with data 0x10..0x17 in order.
  - Grants of 4 words each, with one IDLE cycle between grants.
  - word_count=8 at the end.
- Round robin: all four requesters valid continuously with MAX_BURST=4.
  - Required: grant_id sequence 0,1,2,3,0.
  - Each grant is exactly 4 fifo_write pulses; no requester is skipped.
- Full stall: requester 2 granted; fifo_full=1 for 5 cycles after its 2nd word.
  - Required: fifo_write=0 and req_ready=0 for those 5 cycles, grant held.
  - After full clears, exactly 2 more words are written, then IDLE.
- Early release: requester 1 drops req_valid after 2 words.
  - Required: return to IDLE on the next edge; the next grant goes to requester 2 if it is valid.
  - No extra fifo_write pulse.
- Reset mid-burst: assert areset_n_wr low during the 3rd word of a burst.
  - Required: fifo_write=0 immediately, grant_id=3, word_count=0.
  - After release, requester 0 wins the first arbitration.
- Counter wrap: CWIDTH=4; write 17 words.
  - Required: word_count=1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the dual-clock FIFO write port among NREQ requesters.
// One grant per burst of up to MAX_BURST words; stalls on fifo_full without losing the grant.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 4,
  parameter int CWIDTH    = 16
) (
  input  logic                     wr_clk,
  input  logic                     areset_n_wr,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic [DWIDTH-1:0]        fifo_datain,
  output logic                     fifo_write,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic [CWIDTH-1:0]        word_count
);

  localparam int              IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0]      GID_RST    = 3'(NREQ-1);
  localparam logic [7:0]      BURST_LAST = 8'(MAX_BURST-1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                         r_state, w_state_nxt;
  logic [2:0]                     r_gid, w_gid_nxt;
  logic [7:0]                     r_burst, w_burst_nxt;
  logic [CWIDTH-1:0]              r_wcnt;
  logic [2:0]                     w_sel;
  logic                           w_sel_found;
  logic [IW-1:0]                  w_g;
  logic                           w_g_valid;
  logic                           w_accept;
  logic                           w_granted;
  logic [NREQ-1:0][DWIDTH-1:0]    w_data;

  assign w_data    = req_data;
  assign w_g       = r_gid[IW-1:0];
  assign w_g_valid = req_valid[w_g];
  assign w_granted = (r_state == S_GRANT);
  assign w_accept  = w_granted & w_g_valid & ~fifo_full;

  // Search starts just past the last grant, so the previous winner ranks lowest.
  always_comb begin : rr_pick
    logic [IW-1:0] idx;
    w_sel       = r_gid;
    w_sel_found = 1'b0;
    idx         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(r_gid) + k) % NREQ);
      if (!w_sel_found && req_valid[idx]) begin
        w_sel       = 3'(idx);
        w_sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gid_nxt   = r_gid;
    w_burst_nxt = r_burst;
    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_gid_nxt   = w_sel;
          w_burst_nxt = '0;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_accept) w_burst_nxt = r_burst + 8'd1;
        // Release wins over a full stall; a stall alone holds the grant.
        if (!w_g_valid || (w_accept && r_burst == BURST_LAST)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge areset_n_wr) begin
    if (!areset_n_wr) begin
      r_state <= S_IDLE;
      r_gid   <= GID_RST;
      r_burst <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gid   <= w_gid_nxt;
      r_burst <= w_burst_nxt;
      if (w_accept) r_wcnt <= r_wcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign req_ready[i] = w_granted & (r_gid == 3'(i)) & ~fifo_full;
  end

  assign fifo_write  = w_accept;
  assign fifo_datain = w_data[w_g];
  assign grant_id    = r_gid;
  assign busy        = w_granted;
  assign word_count  = r_wcnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed + random bench for fifo_wr_arbiter against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DW = 8, MB = 4, CW = 4;

  logic                  wr_clk = 1'b0;
  logic                  areset_n_wr;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*DW-1:0]    req_data;
  logic                  fifo_full, fifo_write, busy;
  logic [DW-1:0]         fifo_datain;
  logic [2:0]            grant_id;
  logic [CW-1:0]         word_count;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .MAX_BURST(MB), .CWIDTH(CW)) dut (
    .wr_clk(wr_clk), .areset_n_wr(areset_n_wr), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_datain(fifo_datain),
    .fifo_write(fifo_write), .grant_id(grant_id), .busy(busy), .word_count(word_count));

  always #5 wr_clk = ~wr_clk;

  int errors = 0, checks = 0;

  // Model: who holds the port, words taken in this grant, total words.
  bit   m_busy;
  int   m_g, m_n, m_words;
  logic [7:0] seq [NREQ];
  logic [7:0] wlog [$];
  int   glog [$];
  bit   prev_busy;
  int   obs_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = NREQ-1; m_n = 0; m_words = 0; prev_busy = 0;
  endtask

  task automatic cycle(input logic [NREQ-1:0] v, input logic full);
    logic [NREQ-1:0][DW-1:0] d;
    logic [NREQ-1:0] exp_rdy;
    logic exp_wr;
    bit found;
    @(negedge wr_clk);
    for (int i = 0; i < NREQ; i++) d[i] = seq[i];
    req_valid = v; fifo_full = full; req_data = d;
    #1;
    exp_wr  = m_busy && v[m_g] && !full;
    exp_rdy = (m_busy && !full) ? (NREQ'(1) << m_g) : '0;
    chk("busy",        32'(busy),        32'(m_busy));
    chk("grant_id",    32'(grant_id),    32'(m_g));
    chk("req_ready",   32'(req_ready),   32'(exp_rdy));
    chk("fifo_write",  32'(fifo_write),  32'(exp_wr));
    chk("fifo_datain", 32'(fifo_datain), 32'(seq[m_g]));
    chk("word_count",  32'(word_count),  32'(m_words % (1 << CW)));
    if (busy === 1'b1 && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = (busy === 1'b1);
    if (fifo_write === 1'b1) begin wlog.push_back(fifo_datain); obs_wr++; end
    @(posedge wr_clk);
    if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++)
        if (!found && v[(m_g + k) % NREQ]) begin
          found = 1; m_g = (m_g + k) % NREQ;
        end
      if (found) begin m_busy = 1; m_n = 0; end
    end else begin
      if (exp_wr) begin seq[m_g]++; m_n++; m_words++; end
      if (!v[m_g] || m_n == MB) m_busy = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    req_valid = '0; fifo_full = 1'b0; areset_n_wr = 1'b0;
    model_reset();
    #1;
    chk("rst_busy",   32'(busy),       32'(0));
    chk("rst_write",  32'(fifo_write), 32'(0));
    chk("rst_ready",  32'(req_ready),  32'(0));
    chk("rst_gid",    32'(grant_id),   32'(3));
    chk("rst_wcount", 32'(word_count), 32'(0));
    @(negedge wr_clk);
    areset_n_wr = 1'b1;
    wlog.delete(); glog.delete(); obs_wr = 0;
  endtask

  initial begin
    areset_n_wr = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) seq[i] = 8'(i * 8'h40);
    model_reset();

    // Single requester streaming 0x10..0x17
    do_reset();
    seq[0] = 8'h10;
    for (int k = 0; k < 40 && m_words < 8; k++) cycle(4'b0001, 1'b0);
    chk("single_nwords", 32'(wlog.size()), 32'(8));
    for (int i = 0; i < 8 && i < wlog.size(); i++) chk("single_data", 32'(wlog[i]), 32'(8'h10 + i));
    @(negedge wr_clk); #1;
    chk("single_wcount", 32'(word_count), 32'(8));

    // Round robin, all valid
    do_reset();
    for (int k = 0; k < 40 && glog.size() < 5; k++) cycle(4'b1111, 1'b0);
    chk("rr_ngrants", 32'(glog.size()), 32'(5));
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(i % NREQ));

    // Full stall on requester 2 after its second word
    do_reset();
    seq[2] = 8'h20;
    for (int k = 0; k < 20 && m_words < 2; k++) cycle(4'b0100, 1'b0);
    obs_wr = 0;
    for (int k = 0; k < 5; k++) cycle(4'b0100, 1'b1);
    chk("stall_writes", 32'(obs_wr), 32'(0));
    chk("stall_busy",   32'(busy),     32'(1));
    chk("stall_gid",    32'(grant_id), 32'(2));
    for (int k = 0; k < 3; k++) cycle(4'b0100, 1'b0);
    chk("stall_after", 32'(obs_wr), 32'(2));
    chk("stall_wcount", 32'(word_count), 32'(4));

    // Early release of requester 1 after two words
    do_reset();
    seq[1] = 8'h30;
    for (int k = 0; k < 20 && m_words < 2; k++) cycle(4'b0010, 1'b0);
    obs_wr = 0;
    cycle(4'b0100, 1'b0);
    chk("rel_nowrite", 32'(obs_wr), 32'(0));
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    chk("rel_next_gid",  32'(grant_id), 32'(2));
    chk("rel_next_busy", 32'(busy),     32'(1));

    // Reset during the third word of a burst
    do_reset();
    for (int k = 0; k < 20 && m_words < 2; k++) cycle(4'b0001, 1'b0);
    @(negedge wr_clk);
    req_valid = 4'b0001; fifo_full = 1'b0;
    #1;
    chk("mid_pre_write", 32'(fifo_write), 32'(1));
    areset_n_wr = 1'b0;
    #1;
    chk("mid_write",  32'(fifo_write), 32'(0));
    chk("mid_ready",  32'(req_ready),  32'(0));
    chk("mid_gid",    32'(grant_id),   32'(3));
    chk("mid_wcount", 32'(word_count), 32'(0));
    model_reset();
    @(negedge wr_clk);
    areset_n_wr = 1'b1; req_valid = '0;
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    chk("mid_first_gid", 32'(grant_id), 32'(0));

    // Counter wrap at CWIDTH=4
    do_reset();
    for (int k = 0; k < 60 && m_words < 17; k++) cycle(4'b0001, 1'b0);
    @(negedge wr_clk); #1;
    chk("wrap_wcount", 32'(word_count), 32'(1));

    // Random traffic with random full
    do_reset();
    for (int k = 0; k < 400; k++)
      cycle(NREQ'($urandom), ($urandom_range(0, 3) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
